// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and helpers for the hazard controller
// Purpose: forwarding-select encodings, the "operand unused" Tuse value,
//          default MDU latencies and small helpers shared by the hazard
//          controller and its bench.
// Ports:   none (package).
package hazard_ctrl_pkg;

    // Forwarding mux selects: register file, or the E/M/W stage result.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Tuse value meaning the operand is never read.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default MDU busy periods after the start instruction leaves E.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Tnew one stage later: counts down and saturates at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A stage can supply a source only if it writes that (non-zero)
    // register and its result already exists.
    function automatic logic fwd_hit(input logic [4:0] src,
                                     input logic [4:0] wr,
                                     input logic [1:0] tnew);
        return (src != 5'd0) && (src == wr) && (tnew == 2'd0);
    endfunction

endpackage

// File: rtl/hazard_md_cnt.sv
// rtl/hazard_md_cnt.sv - multiply/divide unit busy counter
// Purpose: loads the MDU latency when a mult/div leaves E, then counts down;
//          busy while nonzero.
// Ports:   clk, reset (sync, active-high)
//          i_start  - mult/div start is in the E stage this cycle
//          i_div    - qualifies i_start: 1 = div, 0 = mult
//          o_busy   - counter nonzero
module hazard_md_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] LP_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LP_DIV  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_div ? LP_DIV : LP_MULT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage MIPS pipeline
// Purpose: tracks destination, Tnew and sources of the E/M/W instructions in a
//          shadow pipeline, compares D-stage Tuse against downstream Tnew to
//          stall, and picks the nearest ready producer for each operand.
// Ports:   clk, reset (sync, active-high)
//          rs_D/rt_D, tuse_rs_D/tuse_rt_D, wr_D, tnew_D  - D-stage decode info
//          md_use_D, md_start_D, md_div_D                - D-stage MDU info
//          en_F, en_D, flush_E                           - pipeline control
//          fwd_rs_D/fwd_rt_D/fwd_rs_E/fwd_rt_E/fwd_rt_M  - forwarding selects
//          md_busy                                       - MDU counter nonzero
//          stall_cnt, md_stall_cnt                       - only with HAZARD_PERF_EN
// Build option: HAZARD_PERF_EN adds the two stall performance counters.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  wr_D,
    input  logic [1:0]  tnew_D,
    input  logic        md_use_D,
    input  logic        md_start_D,
    input  logic        md_div_D,
    output logic        en_F,
    output logic        en_D,
    output logic        flush_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        fwd_rt_M,
    output logic        md_busy
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    // Shadow pipeline. Only the fields that later logic reads are kept per
    // stage: W needs just its destination since its Tnew is always zero.
    logic [4:0] r_wr_E, r_rs_E, r_rt_E;
    logic [1:0] r_tnew_E;
    logic       r_md_start_E, r_md_div_E;
    logic [4:0] r_wr_M, r_rt_M;
    logic [1:0] r_tnew_M;
    logic [4:0] r_wr_W;

    logic w_stall_rs, w_stall_rt, w_md_stall, w_stall, w_md_busy;

    // A source stalls when a downstream producer of it will not have its
    // result ready by the time D needs it. Tuse = 3 can never be below a
    // Tnew of at most 2, so unused operands fall out naturally.
    assign w_stall_rs = (rs_D != 5'd0) &&
                        (((rs_D == r_wr_E) && (tuse_rs_D < r_tnew_E)) ||
                         ((rs_D == r_wr_M) && (tuse_rs_D < r_tnew_M)));
    assign w_stall_rt = (rt_D != 5'd0) &&
                        (((rt_D == r_wr_E) && (tuse_rt_D < r_tnew_E)) ||
                         ((rt_D == r_wr_M) && (tuse_rt_D < r_tnew_M)));

    // A start sitting in E has not loaded the counter yet, so it blocks
    // MDU users in D for that cycle too.
    assign w_md_stall = md_use_D && (w_md_busy || r_md_start_E);
    assign w_stall    = w_stall_rs || w_stall_rt || w_md_stall;

    assign en_F    = ~w_stall;
    assign en_D    = ~w_stall;
    assign flush_E = w_stall;
    assign md_busy = w_md_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_E       <= '0;
            r_rs_E       <= '0;
            r_rt_E       <= '0;
            r_tnew_E     <= '0;
            r_md_start_E <= 1'b0;
            r_md_div_E   <= 1'b0;
            r_wr_M       <= '0;
            r_rt_M       <= '0;
            r_tnew_M     <= '0;
            r_wr_W       <= '0;
        end else begin
            if (w_stall) begin
                // Bubble: mirrors the D/E clear.
                r_wr_E       <= '0;
                r_rs_E       <= '0;
                r_rt_E       <= '0;
                r_tnew_E     <= '0;
                r_md_start_E <= 1'b0;
                r_md_div_E   <= 1'b0;
            end else begin
                r_wr_E       <= wr_D;
                r_rs_E       <= rs_D;
                r_rt_E       <= rt_D;
                r_tnew_E     <= tnew_D;
                r_md_start_E <= md_start_D;
                r_md_div_E   <= md_div_D;
            end
            r_wr_M   <= r_wr_E;
            r_rt_M   <= r_rt_E;
            r_tnew_M <= tnew_dec(r_tnew_E);
            r_wr_W   <= r_wr_M;
        end
    end

    // Nearest ready producer wins.
    always_comb begin
        fwd_rs_D = FWD_RF;
        if (fwd_hit(rs_D, r_wr_E, r_tnew_E))      fwd_rs_D = FWD_E;
        else if (fwd_hit(rs_D, r_wr_M, r_tnew_M)) fwd_rs_D = FWD_M;
        else if (fwd_hit(rs_D, r_wr_W, 2'd0))     fwd_rs_D = FWD_W;

        fwd_rt_D = FWD_RF;
        if (fwd_hit(rt_D, r_wr_E, r_tnew_E))      fwd_rt_D = FWD_E;
        else if (fwd_hit(rt_D, r_wr_M, r_tnew_M)) fwd_rt_D = FWD_M;
        else if (fwd_hit(rt_D, r_wr_W, 2'd0))     fwd_rt_D = FWD_W;

        fwd_rs_E = FWD_RF;
        if (fwd_hit(r_rs_E, r_wr_M, r_tnew_M))    fwd_rs_E = FWD_M;
        else if (fwd_hit(r_rs_E, r_wr_W, 2'd0))   fwd_rs_E = FWD_W;

        fwd_rt_E = FWD_RF;
        if (fwd_hit(r_rt_E, r_wr_M, r_tnew_M))    fwd_rt_E = FWD_M;
        else if (fwd_hit(r_rt_E, r_wr_W, 2'd0))   fwd_rt_E = FWD_W;

        fwd_rt_M = fwd_hit(r_rt_M, r_wr_W, 2'd0);
    end

    hazard_md_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_start (r_md_start_E),
        .i_div   (r_md_div_E),
        .o_busy  (w_md_busy)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt, r_md_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt    <= '0;
            r_md_stall_cnt <= '0;
        end else begin
            if (w_stall)    r_stall_cnt    <= r_stall_cnt + 32'd1;
            if (w_md_stall) r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`else
    // No stall performance counters in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
import hazard_ctrl_pkg::*;

module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D, rt_D, wr_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
    logic       md_use_D, md_start_D, md_div_D;
    logic       en_F, en_D, flush_E;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic       fwd_rt_M, md_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    int n_cmp;
    int n_fail;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .wr_D       (wr_D),
        .tnew_D     (tnew_D),
        .md_use_D   (md_use_D),
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .en_F       (en_F),
        .en_D       (en_D),
        .flush_E    (flush_E),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .fwd_rt_M   (fwd_rt_M),
        .md_busy    (md_busy)
`ifdef HAZARD_PERF_EN
       ,.stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [1:0] trs, input logic [1:0] trt,
                           input logic [4:0] wr, input logic [1:0] tn,
                           input logic mu, input logic ms, input logic md);
        rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
        wr_D = wr; tnew_D = tn;
        md_use_D = mu; md_start_D = ms; md_div_D = md;
    endtask

    task automatic drive_nop;
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain;
        drive_nop();
        repeat (3) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_nop();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL reset_ctrl: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M} !== 9'd0) begin
            $display("FAIL reset_fwd: got %b expected 0", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}); n_fail++;
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", md_busy); n_fail++;
        end
    endtask

    // lw $1 then beq on $1: two bubbles, then $1 comes from W.
    task automatic test_load_hazard;
        drive_d(5'd5, 5'd0, 2'd1, TUSE_NONE, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive_d(5'd1, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b001) begin
            $display("FAIL load_stall1: got %b expected 001", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if (fwd_rs_D !== FWD_RF) begin
            $display("FAIL load_fwd_during_stall: got %0d expected 0", fwd_rs_D); n_fail++;
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b001) begin
            $display("FAIL load_stall2: got %b expected 001", {en_F, en_D, flush_E}); n_fail++;
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL load_release: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if (fwd_rs_D !== FWD_W) begin
            $display("FAIL load_fwd_W: got %0d expected 3", fwd_rs_D); n_fail++;
        end
        drain();
    endtask

    // addu $2 then addu reading $2 at E: no stall, E forwards from M.
    task automatic test_alu_hazard;
        drive_d(5'd3, 5'd4, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_d(5'd2, 5'd6, 2'd1, 2'd1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL alu_no_stall: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if (fwd_rs_D !== FWD_RF) begin
            $display("FAIL alu_fwd_rs_D: got %0d expected 0", fwd_rs_D); n_fail++;
        end
        tick();
        drive_nop();
        @(negedge clk);
        n_cmp++;
        if ({fwd_rs_E, fwd_rt_E} !== {FWD_M, FWD_RF}) begin
            $display("FAIL alu_fwd_E: got rs=%0d rt=%0d expected rs=2 rt=0", fwd_rs_E, fwd_rt_E); n_fail++;
        end
        drain();
    endtask

    task automatic test_jal_jr;
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_d(5'd31, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL jr_no_stall: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if (fwd_rs_D !== FWD_E) begin
            $display("FAIL jr_fwd_E: got %0d expected 1", fwd_rs_D); n_fail++;
        end
        drain();
    endtask

    // addu $7 then sw $7: rt forwarded M->E, then W->M for store data.
    task automatic test_store_fwd;
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_d(5'd0, 5'd7, TUSE_NONE, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL sw_no_stall: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        tick();
        drive_nop();
        @(negedge clk);
        n_cmp++;
        if (fwd_rt_E !== FWD_M) begin
            $display("FAIL sw_fwd_rt_E: got %0d expected 2", fwd_rt_E); n_fail++;
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (fwd_rt_M !== 1'b1) begin
            $display("FAIL sw_fwd_rt_M: got %0d expected 1", fwd_rt_M); n_fail++;
        end
        drain();
    endtask

    task automatic test_reg_zero;
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL zero_no_stall: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if ({fwd_rs_D, fwd_rt_D} !== 4'd0) begin
            $display("FAIL zero_no_fwd: got %b expected 0000", {fwd_rs_D, fwd_rt_D}); n_fail++;
        end
        drain();
    endtask

    // Two lui $8 back to back, then a reader: E beats M beats W.
    task automatic test_priority;
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive_d(5'd8, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (fwd_rs_D !== FWD_E) begin
            $display("FAIL prio_E: got %0d expected 1", fwd_rs_D); n_fail++;
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (fwd_rs_D !== FWD_M) begin
            $display("FAIL prio_M: got %0d expected 2", fwd_rs_D); n_fail++;
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (fwd_rs_D !== FWD_W) begin
            $display("FAIL prio_W: got %0d expected 3", fwd_rs_D); n_fail++;
        end
        drain();
    endtask

    // mult/div in E followed by mflo in D: 1 + N stall cycles, N busy cycles.
    task automatic test_mdu(input logic is_div, input int exp_stall, input int exp_busy);
        int  n_stall;
        int  n_flush;
        int  n_busy;
        logic released;
        n_stall = 0; n_flush = 0; n_busy = 0; released = 1'b0;
        drive_d(5'd9, 5'd10, 2'd1, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, is_div);
        tick();
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd11, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30 && !released; i++) begin
            @(negedge clk);
            if (md_busy === 1'b1) n_busy++;
            if (en_F === 1'b1) begin
                released = 1'b1;
            end else begin
                n_stall++;
                if (flush_E === 1'b1) n_flush++;
                tick();
            end
        end
        n_cmp++;
        if (released !== 1'b1) begin
            $display("FAIL mdu_release(div=%0d): no release within 30 cycles", is_div); n_fail++;
        end
        n_cmp++;
        if (n_stall != exp_stall || n_flush != exp_stall) begin
            $display("FAIL mdu_stall(div=%0d): got stall=%0d flush=%0d expected %0d", is_div, n_stall, n_flush, exp_stall); n_fail++;
        end
        n_cmp++;
        if (n_busy != exp_busy) begin
            $display("FAIL mdu_busy(div=%0d): got %0d expected %0d", is_div, n_busy, exp_busy); n_fail++;
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            $display("FAIL mdu_idle_at_release(div=%0d): got %b expected 0", is_div, md_busy); n_fail++;
        end
        drain();
    endtask

    task automatic test_reset_mid_busy;
        drive_d(5'd9, 5'd10, 2'd1, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1);
        tick();
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd11, 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({md_busy, en_F} !== 2'b10) begin
            $display("FAIL midrst_pre: got busy/en_F=%b expected 10", {md_busy, en_F}); n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (md_busy !== 1'b0) begin
            $display("FAIL midrst_busy: got %b expected 0", md_busy); n_fail++;
        end
        n_cmp++;
        if ({en_F, en_D, flush_E} !== 3'b110) begin
            $display("FAIL midrst_ctrl: got %b expected 110", {en_F, en_D, flush_E}); n_fail++;
        end
        n_cmp++;
        if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M} !== 9'd0) begin
            $display("FAIL midrst_fwd: got %b expected 0", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}); n_fail++;
        end
        drain();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive_nop();
        test_reset();
        test_load_hazard();
        test_alu_hazard();
        test_jal_jr();
        test_store_fwd();
        test_reg_zero();
        test_priority();
        test_mdu(1'b1, 11, 10);
        test_mdu(1'b0, 6, 5);
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
